pim_ctrl: RTL and testbench
===========================

# pim_ctrl

Command sequencer that sits between the CPU's CFU port and the `pim_model` array macro, acting as the initiator for the macro's memory and MAC pins. It accepts one CFU command at a time. Each command is translated into a row write, a row read, an activation-buffer update or a bit-serial MAC sequence on the macro pins. The captured result is returned on the CFU response channel.

## Interface
Parameters:
- `DWIDTH`, 32: width of the macro `mac_out`.
- `AWIDTH`, 8: width of the row address.
- `PWIDTH`, 32: row width, matching macro `d`/`q`.
- `PDEPTH`, `1<<AWIDTH`: number of rows, which is also the `rwl` width.
- `IBITS`, 4: activation bit width, i.e. the number of bit-serial MAC planes (1..16).

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-low reset.
- `cmd_valid` in 1: command valid.
- `cmd_ready` out 1: command ready.
- `cmd_payload_function_id` in 10: bits [2:0] select the opcode; the other bits are ignored.
- `cmd_payload_inputs_0` in 32: operand A.
- `cmd_payload_inputs_1` in 32: operand B.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response accepted.
- `rsp_payload_outputs_0` out 32: response data.
- `pim_d` out PWIDTH: write data to the macro.
- `pim_addr` out AWIDTH: row address.
- `pim_rwl` out PDEPTH: read-wordline vector.
- `pim_w_en` out 1: macro write enable.
- `pim_p_en` out 1: macro processing enable.
- `pim_q` in PWIDTH: macro read data, registered in the macro with 1-cycle latency.
- `pim_mac_out` in DWIDTH: macro MAC result.

## Operation
Opcodes (`function_id[2:0]`):
- 0 WRITE: row = A[AWIDTH-1:0], data = B[PWIDTH-1:0]. Response = 0.
- 1 READ: row = A[AWIDTH-1:0]. Response = row contents, zero-extended to 32 bits.
- 2 SET_ACT: `act[A[AWIDTH-1:0]] <= B[IBITS-1:0]`. Response = 0.
- 3 MAC: runs the sequence below over all PDEPTH activations. Response = `pim_mac_out`, truncated or zero-extended to 32 bits.
- 4 CLR_ACT: all activations set to 0. Response = 0.
- 5 PERF: see Configuration.
- 6, 7: no-op. Response = 0.

Activation buffer:
- PDEPTH × IBITS register array.
- Cleared by reset and by CLR_ACT.

Address handling:
- Out-of-range operand bits are ignored; only the low bits are used, so addresses wrap.

FSM states and pin drive:
- IDLE: `cmd_ready=1`, `pim_p_en=0`, `pim_w_en=0`, `pim_rwl=0`. A command is accepted when `cmd_valid && cmd_ready`; operands are latched at acceptance.
- WR: one cycle driving `pim_addr`, `pim_d` and `pim_w_en=1`, then RSP.
- RD_A: one cycle driving `pim_addr` with `pim_w_en=0` and `pim_p_en=0`, then RD_C.
- RD_C: latches `pim_q`, then RSP.
- MAC_RUN: IBITS cycles with `pim_p_en=1` and `pim_rwl[j] = act[j][k]`, where the plane index k runs 0..IBITS-1, LSB first.
- MAC_DRN: 2 cycles with `pim_p_en=1` and `pim_rwl=0`. This lets the macro's accumulator, sum and output registers settle while shifted zeros add nothing.
- MAC_CAP: `pim_p_en=0`; latches `pim_mac_out`, then RSP.
- RSP: `rsp_valid=1` with `rsp_payload_outputs_0` held stable until `rsp_ready`, then IDLE.
- `cmd_ready=0` in every state except IDLE; no command is accepted while a response is pending.

Macro pin rules:
- `pim_p_en` is always low for at least one cycle before a MAC starts, because IDLE is always between commands. This guarantees the macro's shift counter restarts at 0.
- `pim_addr` and `pim_d` hold their last driven value when not in use.

## Timing
Latencies, measured from the acceptance cycle T to the first `rsp_valid` cycle:
- SET_ACT, CLR_ACT, PERF, NOP: T+1.
- WRITE: T+2.
- READ: T+3.
- MAC: T+IBITS+4.

Reset:
- Synchronous active-low reset applies on any edge with `reset=0`, including mid-MAC or mid-response. The FSM returns to IDLE, any pending response is dropped, and the activation buffer is cleared.
- Reset values: `cmd_ready=1`, `rsp_valid=0`, `rsp_payload_outputs_0=0`, `pim_d=0`, `pim_addr=0`, `pim_rwl=0`, `pim_w_en=0`, `pim_p_en=0`.

Other timing rules:
- `rsp_ready` may already be high when RSP is entered; RSP then lasts exactly 1 cycle and IDLE follows.
- Back-to-back throughput: the next command is accepted no earlier than the cycle after the response handshake.

## Configuration
- `PIM_CTRL_PERF_EN` defined:
  - A 32-bit counter increments on every cycle spent in MAC_RUN, MAC_DRN or MAC_CAP.
  - The counter saturates at 0xFFFFFFFF and is cleared by reset.
  - PERF returns the count; when A[0]=1 it also clears the counter after sampling.
- `PIM_CTRL_PERF_EN` undefined: no counter is built and PERF returns 0.

## Test plan
- Reset with `reset=0` for 2 cycles -> all outputs at their reset values; `cmd_ready=1`.
- WRITE A=5, B=0xDEADBEEF, then READ A=5 -> `pim_w_en` pulses one cycle at `pim_addr=5`; the READ response is 0xDEADBEEF at T+3.
- Write row0=0x3, row1=0x1; SET_ACT row0=2, row1=3; MAC with IBITS=4 -> `pim_rwl` bit-planes 0b10, 0b11, 0b00, 0b00, then 2 cycles of 0. Response = 2·2 + 3·1 + 2·1 (column-weighted popcount sum as the macro computes it) = 9 at T+8.
- MAC response with `rsp_ready` held low for 5 cycles -> `rsp_valid` and data stable for all 5 cycles; `cmd_valid` asserted during that time is not accepted.
- `reset=0` asserted at MAC_RUN plane 2 -> next cycle `pim_p_en=0`, `pim_rwl=0`, no response issued; a following READ of row 0 returns 0x3.
- With `PIM_CTRL_PERF_EN` defined, one MAC (IBITS=4) followed by PERF A=1 returns 7; a second PERF returns 0.

Source files
------------

// File: rtl/pim_ctrl_if.sv
// CFU command/response channel between the CPU and pim_ctrl.
// The CPU drives the master side; the controller sits on the slave side.
interface pim_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0;
  logic [31:0] cmd_payload_inputs_1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_payload_outputs_0;

  modport master (
    output cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0,
           cmd_payload_inputs_1, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_payload_outputs_0
  );

  modport slave (
    input  cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0,
           cmd_payload_inputs_1, rsp_ready,
    output cmd_ready, rsp_valid, rsp_payload_outputs_0
  );
endinterface

// File: rtl/pim_ctrl.sv
// pim_ctrl: sequences one CFU command at a time onto the pim_model macro pins
// (row write, row read, activation update, bit-serial MAC) and returns the
// captured result on the CFU response channel.
// Optional feature: define PIM_CTRL_PERF_EN to build a saturating counter of
// MAC cycles readable through the PERF opcode; otherwise PERF returns 0.
module pim_ctrl #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 8,
  parameter int PWIDTH = 32,
  parameter int PDEPTH = 1 << AWIDTH,
  parameter int IBITS  = 4
) (
  input  logic              clk,
  input  logic              reset,
  pim_ctrl_if.slave         cfu,
  output logic [PWIDTH-1:0] pim_d,
  output logic [AWIDTH-1:0] pim_addr,
  output logic [PDEPTH-1:0] pim_rwl,
  output logic              pim_w_en,
  output logic              pim_p_en,
  input  logic [PWIDTH-1:0] pim_q,
  input  logic [DWIDTH-1:0] pim_mac_out
);

  localparam int PW = (IBITS > 1) ? $clog2(IBITS) : 1;

  typedef enum logic [2:0] {
    OP_WRITE   = 3'd0,
    OP_READ    = 3'd1,
    OP_SET_ACT = 3'd2,
    OP_MAC     = 3'd3,
    OP_CLR_ACT = 3'd4,
    OP_PERF    = 3'd5
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_RD_A, S_RD_C, S_MAC_RUN, S_MAC_DRN, S_MAC_CAP, S_RSP
  } state_e;

  state_e            state_q;
  logic [PW-1:0]     plane_q;
  logic              drn_q;
  logic [IBITS-1:0]  act_q [PDEPTH];
  logic              cmd_ready_q;
  logic              rsp_valid_q;
  logic [31:0]       rsp_data_q;
  logic [PWIDTH-1:0] d_q;
  logic [AWIDTH-1:0] addr_q;
  logic [PDEPTH-1:0] rwl_q;
  logic              w_en_q;
  logic              p_en_q;

  logic [PW-1:0]     plane_idx;
  logic [PDEPTH-1:0] plane_vec;
  logic [31:0]       perf_rd;
  op_e               op;

  assign op = op_e'(cfu.cmd_payload_function_id[2:0]);

  // Bit-plane to drive next: plane 0 when a MAC starts, else the one after plane_q.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    plane_idx = '0;
    plane_vec = '0;
    if (state_q == S_MAC_RUN && plane_q != PW'(IBITS - 1))
      plane_idx = plane_q + 1'b1;
    for (int j = 0; j < PDEPTH; j++)
      plane_vec[j] = act_q[j][plane_idx];
  end

  // Command FSM with registered pin/response outputs and the activation buffer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      plane_q     <= '0;
      drn_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      d_q         <= '0;
      addr_q      <= '0;
      rwl_q       <= '0;
      w_en_q      <= 1'b0;
      p_en_q      <= 1'b0;
      // NOTE: the activation buffer is architecturally cleared by reset, so this array is reset on purpose.
      for (int j = 0; j < PDEPTH; j++) act_q[j] <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (cfu.cmd_valid) begin
            cmd_ready_q <= 1'b0;
            rsp_data_q  <= '0;
            case (op)
              OP_WRITE: begin
                addr_q  <= AWIDTH'(cfu.cmd_payload_inputs_0);
                d_q     <= PWIDTH'(cfu.cmd_payload_inputs_1);
                w_en_q  <= 1'b1;
                state_q <= S_WR;
              end
              OP_READ: begin
                addr_q  <= AWIDTH'(cfu.cmd_payload_inputs_0);
                state_q <= S_RD_A;
              end
              OP_SET_ACT: begin
                act_q[AWIDTH'(cfu.cmd_payload_inputs_0)] <= IBITS'(cfu.cmd_payload_inputs_1);
                rsp_valid_q <= 1'b1;
                state_q     <= S_RSP;
              end
              OP_MAC: begin
                p_en_q  <= 1'b1;
                rwl_q   <= plane_vec;
                plane_q <= '0;
                state_q <= S_MAC_RUN;
              end
              OP_CLR_ACT: begin
                for (int j = 0; j < PDEPTH; j++) act_q[j] <= '0;
                rsp_valid_q <= 1'b1;
                state_q     <= S_RSP;
              end
              OP_PERF: begin
                rsp_data_q  <= perf_rd;
                rsp_valid_q <= 1'b1;
                state_q     <= S_RSP;
              end
              default: begin
                rsp_valid_q <= 1'b1;
                state_q     <= S_RSP;
              end
            endcase
          end
        end
        S_WR: begin
          w_en_q      <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= S_RSP;
        end
        S_RD_A: state_q <= S_RD_C;
        S_RD_C: begin
          rsp_data_q  <= 32'(pim_q);
          rsp_valid_q <= 1'b1;
          state_q     <= S_RSP;
        end
        S_MAC_RUN: begin
          if (plane_q == PW'(IBITS - 1)) begin
            rwl_q   <= '0;
            drn_q   <= 1'b0;
            state_q <= S_MAC_DRN;
          end else begin
            rwl_q   <= plane_vec;
            plane_q <= plane_q + 1'b1;
          end
        end
        S_MAC_DRN: begin
          // Two zero-plane cycles flush the macro's accumulate pipeline.
          if (drn_q) begin
            p_en_q  <= 1'b0;
            state_q <= S_MAC_CAP;
          end else begin
            drn_q <= 1'b1;
          end
        end
        S_MAC_CAP: begin
          rsp_data_q  <= 32'(pim_mac_out);
          rsp_valid_q <= 1'b1;
          state_q     <= S_RSP;
        end
        S_RSP: begin
          if (cfu.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef PIM_CTRL_PERF_EN
  logic [31:0] perf_q;
  logic        perf_clr;
  logic        in_mac;

  assign in_mac   = (state_q == S_MAC_RUN) || (state_q == S_MAC_DRN) || (state_q == S_MAC_CAP);
  assign perf_clr = (state_q == S_IDLE) && cfu.cmd_valid && (op == OP_PERF) &&
                    cfu.cmd_payload_inputs_0[0];

  // Saturating count of cycles spent in the MAC states; PERF with A[0]=1 clears it.
  always_ff @(posedge clk) begin
    if (!reset)                       perf_q <= '0;
    else if (perf_clr)                perf_q <= '0;
    else if (in_mac && perf_q != '1)  perf_q <= perf_q + 32'd1;
  end

  assign perf_rd = perf_q;
`else
  assign perf_rd = '0;
`endif

  // Operand bits beyond the used address/data/activation widths are ignored.
  logic unused_bits;
  assign unused_bits = ^{cfu.cmd_payload_function_id, cfu.cmd_payload_inputs_0,
                         cfu.cmd_payload_inputs_1, pim_q, pim_mac_out};

  assign cfu.cmd_ready             = cmd_ready_q;
  assign cfu.rsp_valid             = rsp_valid_q;
  assign cfu.rsp_payload_outputs_0 = rsp_data_q;
  assign pim_d    = d_q;
  assign pim_addr = addr_q;
  assign pim_rwl  = rwl_q;
  assign pim_w_en = w_en_q;
  assign pim_p_en = p_en_q;

endmodule

// File: tb/tb_pim_ctrl.sv
// Directed testbench for pim_ctrl with a behavioural pim_model macro and a
// response scoreboard. Build with PIM_CTRL_PERF_EN to also exercise PERF.
module tb_pim_ctrl;
  localparam int DWIDTH = 32;
  localparam int AWIDTH = 8;
  localparam int PWIDTH = 32;
  localparam int PDEPTH = 256;
  localparam int IBITS  = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pim_ctrl_if cfu ();

  logic [PWIDTH-1:0] pim_d;
  logic [AWIDTH-1:0] pim_addr;
  logic [PDEPTH-1:0] pim_rwl;
  logic              pim_w_en;
  logic              pim_p_en;
  logic [PWIDTH-1:0] pim_q;
  logic [DWIDTH-1:0] pim_mac_out;

  pim_ctrl #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .PWIDTH(PWIDTH), .PDEPTH(PDEPTH), .IBITS(IBITS)) dut (
    .clk(clk), .reset(reset), .cfu(cfu),
    .pim_d(pim_d), .pim_addr(pim_addr), .pim_rwl(pim_rwl), .pim_w_en(pim_w_en),
    .pim_p_en(pim_p_en), .pim_q(pim_q), .pim_mac_out(pim_mac_out)
  );

  // Behavioural macro: registered read, bit-serial MAC with shift-add accumulate.
  logic [PWIDTH-1:0] mem [PDEPTH];
  logic [63:0] m_sum_q, m_acc_q;
  int          m_cnt_q, m_sh_q;
  initial begin
    for (int j = 0; j < PDEPTH; j++) mem[j] = '0;
    m_sum_q = '0; m_acc_q = '0; m_cnt_q = 0; m_sh_q = 0; pim_q = '0;
  end
  always @(posedge clk) begin
    logic [63:0] s;
    if (pim_w_en) mem[pim_addr] <= pim_d;
    pim_q <= mem[pim_addr];
    s = '0;
    for (int j = 0; j < PDEPTH; j++) if (pim_rwl[j]) s = s + 64'(mem[j]);
    if (!pim_p_en) begin
      m_sum_q <= '0; m_acc_q <= '0; m_cnt_q <= 0; m_sh_q <= 0;
    end else begin
      m_sum_q <= s;
      m_sh_q  <= m_cnt_q;
      m_cnt_q <= m_cnt_q + 1;
      m_acc_q <= m_acc_q + (m_sum_q << m_sh_q);
    end
  end
  assign pim_mac_out = m_acc_q[31:0];

  // Reference state kept by the bench.
  logic [PWIDTH-1:0] tb_rows [PDEPTH];
  logic [IBITS-1:0]  tb_act  [PDEPTH];

  typedef struct {
    string       tag;
    logic [31:0] data;
    int          lat;
  } exp_t;
  exp_t sb [$];

  int vectors = 0;
  int miscompares = 0;
  int lat;
  logic [PDEPTH-1:0] snap_rwl  [41];
  logic              snap_pen  [41];
  logic              snap_wen  [41];
  logic [AWIDTH-1:0] snap_addr [41];
  logic [PWIDTH-1:0] snap_d    [41];

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PDEPTH-1:0] exp_plane(input int k);
    logic [PDEPTH-1:0] v;
    v = '0;
    for (int j = 0; j < PDEPTH; j++) v[j] = tb_act[j][k];
    return v;
  endfunction

  function automatic logic [31:0] exp_mac();
    logic [63:0] s;
    s = '0;
    for (int j = 0; j < PDEPTH; j++) s = s + 64'(tb_act[j]) * 64'(tb_rows[j]);
    return s[31:0];
  endfunction

  // Issue one command, snapshot pins each cycle, then score the response.
  // hold > 0 keeps rsp_ready low and offers a competing command meanwhile.
  task automatic run_cmd(input string tag, input logic [9:0] fid, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_data,
                         input int exp_lat, input int hold);
    exp_t got;
    logic [31:0] first;
    @(negedge clk);
    check({tag, "_ready"}, 256'(cfu.cmd_ready), 256'(1));
    cfu.rsp_ready = (hold == 0);
    cfu.cmd_valid = 1'b1;
    cfu.cmd_payload_function_id = fid;
    cfu.cmd_payload_inputs_0 = a;
    cfu.cmd_payload_inputs_1 = b;
    sb.push_back('{tag, exp_data, exp_lat});
    @(posedge clk);
    #1 cfu.cmd_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      snap_rwl[lat] = pim_rwl; snap_pen[lat] = pim_p_en; snap_wen[lat] = pim_w_en;
      snap_addr[lat] = pim_addr; snap_d[lat] = pim_d;
    end while (!cfu.rsp_valid && lat < 40);
    got = sb.pop_front();
    check({tag, "_valid"}, 256'(cfu.rsp_valid), 256'(1));
    check({tag, "_lat"}, 256'(lat), 256'(got.lat));
    check({tag, "_data"}, 256'(cfu.rsp_payload_outputs_0), 256'(got.data));
    first = cfu.rsp_payload_outputs_0;
    for (int h = 0; h < hold - 1; h++) begin
      cfu.cmd_valid = 1'b1;
      cfu.cmd_payload_function_id = 10'd6;
      @(negedge clk);
      check({tag, "_hold_valid"}, 256'(cfu.rsp_valid), 256'(1));
      check({tag, "_hold_data"}, 256'(cfu.rsp_payload_outputs_0), 256'(first));
      check({tag, "_hold_noaccept"}, 256'(cfu.cmd_ready), 256'(0));
    end
    cfu.cmd_valid = 1'b0;
    cfu.rsp_ready = 1'b1;
    @(negedge clk);
    check({tag, "_done"}, 256'(cfu.rsp_valid), 256'(0));
  endtask

  task automatic check_mac_pins(input string tag);
    for (int k = 0; k < IBITS; k++) begin
      check({tag, "_rwl_plane"}, 256'(snap_rwl[k + 1]), 256'(exp_plane(k)));
      check({tag, "_pen_run"}, 256'(snap_pen[k + 1]), 256'(1));
    end
    for (int k = IBITS + 1; k <= IBITS + 2; k++) begin
      check({tag, "_rwl_drain"}, 256'(snap_rwl[k]), 256'(0));
      check({tag, "_pen_drain"}, 256'(snap_pen[k]), 256'(1));
    end
    check({tag, "_pen_cap"}, 256'(snap_pen[IBITS + 3]), 256'(0));
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] b);
    run_cmd("write", 10'd0, a, b, 32'd0, 2, 0);
    tb_rows[a[AWIDTH-1:0]] = b;
  endtask

  task automatic do_set_act(input logic [31:0] a, input logic [31:0] b);
    run_cmd("set_act", 10'd2, a, b, 32'd0, 1, 0);
    tb_act[a[AWIDTH-1:0]] = b[IBITS-1:0];
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic seen;
    for (int j = 0; j < PDEPTH; j++) begin tb_rows[j] = '0; tb_act[j] = '0; end
    cfu.cmd_valid = 1'b0;
    cfu.cmd_payload_function_id = '0;
    cfu.cmd_payload_inputs_0 = '0;
    cfu.cmd_payload_inputs_1 = '0;
    cfu.rsp_ready = 1'b1;

    // Reset for two cycles and check every output's reset value.
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 256'(cfu.cmd_ready), 256'(1));
    check("rst_rsp_valid", 256'(cfu.rsp_valid), 256'(0));
    check("rst_rsp_data", 256'(cfu.rsp_payload_outputs_0), 256'(0));
    check("rst_pim_d", 256'(pim_d), 256'(0));
    check("rst_pim_addr", 256'(pim_addr), 256'(0));
    check("rst_pim_rwl", 256'(pim_rwl), 256'(0));
    check("rst_pim_w_en", 256'(pim_w_en), 256'(0));
    check("rst_pim_p_en", 256'(pim_p_en), 256'(0));
    reset = 1'b1;

    // WRITE row 5 then READ it back, plus a wrapped address with upper function bits set.
    do_write(32'd5, 32'hDEADBEEF);
    check("wr_w_en", 256'(snap_wen[1]), 256'(1));
    check("wr_addr", 256'(snap_addr[1]), 256'(5));
    check("wr_d", 256'(snap_d[1]), 256'(32'hDEADBEEF));
    check("wr_w_en_off", 256'(snap_wen[2]), 256'(0));
    run_cmd("read5", 10'd1, 32'd5, 32'd0, tb_rows[5], 3, 0);
    check("rd_addr", 256'(snap_addr[1]), 256'(5));
    check("rd_w_en", 256'(snap_wen[1]), 256'(0));
    check("rd_p_en", 256'(snap_pen[1]), 256'(0));
    run_cmd("read_wrap", 10'h3F9, 32'h0000_0105, 32'd0, tb_rows[5], 3, 0);

    // Basic MAC: row0=3, row1=1, act0=2, act1=3.
    do_write(32'd0, 32'd3);
    do_write(32'd1, 32'd1);
    do_set_act(32'd0, 32'd2);
    do_set_act(32'd1, 32'd3);
    run_cmd("mac", 10'd3, 32'd0, 32'd0, exp_mac(), IBITS + 4, 0);
    check_mac_pins("mac");

    // Same MAC with a stalled response.
    run_cmd("mac_hold", 10'd3, 32'd0, 32'd0, exp_mac(), IBITS + 4, 5);

    // Wrapped addresses and truncated activation value.
    do_write(32'h0000_0302, 32'h10);
    do_set_act(32'h0000_0102, 32'h1F);
    run_cmd("mac_wrap", 10'd3, 32'd0, 32'd0, exp_mac(), IBITS + 4, 0);
    check_mac_pins("mac_wrap");

    // No-ops, then clearing activations zeroes the MAC.
    run_cmd("nop6", 10'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1, 0);
    run_cmd("nop7", 10'h2F7, 32'd1, 32'd1, 32'd0, 1, 0);
    run_cmd("clr_act", 10'd4, 32'd0, 32'd0, 32'd0, 1, 0);
    for (int j = 0; j < PDEPTH; j++) tb_act[j] = '0;
    run_cmd("mac_clr", 10'd3, 32'd0, 32'd0, exp_mac(), IBITS + 4, 0);

    // Reset in the middle of a MAC: response dropped, activations cleared, rows kept.
    do_set_act(32'd0, 32'd2);
    do_set_act(32'd1, 32'd3);
    @(negedge clk);
    check("rstmac_ready", 256'(cfu.cmd_ready), 256'(1));
    cfu.cmd_valid = 1'b1;
    cfu.cmd_payload_function_id = 10'd3;
    sb.push_back('{"rstmac", exp_mac(), IBITS + 4});
    @(posedge clk);
    #1 cfu.cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rstmac_pen_plane2", 256'(pim_p_en), 256'(1));
    reset = 1'b0;
    @(negedge clk);
    check("rstmac_pen", 256'(pim_p_en), 256'(0));
    check("rstmac_rwl", 256'(pim_rwl), 256'(0));
    check("rstmac_rsp_valid", 256'(cfu.rsp_valid), 256'(0));
    check("rstmac_cmd_ready", 256'(cfu.cmd_ready), 256'(1));
    reset = 1'b1;
    void'(sb.pop_front());
    for (int j = 0; j < PDEPTH; j++) tb_act[j] = '0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (cfu.rsp_valid) seen = 1'b1;
    end
    check("rstmac_no_rsp", 256'(seen), 256'(0));
    run_cmd("rstmac_read0", 10'd1, 32'd0, 32'd0, tb_rows[0], 3, 0);
    run_cmd("rstmac_mac", 10'd3, 32'd0, 32'd0, exp_mac(), IBITS + 4, 0);

`ifdef PIM_CTRL_PERF_EN
    run_cmd("perf_clr", 10'd5, 32'd1, 32'd0, 32'(IBITS + 3), 1, 0);
    run_cmd("perf_after", 10'd5, 32'd0, 32'd0, 32'd0, 1, 0);
`else
    run_cmd("perf_off", 10'd5, 32'd1, 32'd0, 32'd0, 1, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
